// File: rtl/y_zigzag_scanner_if.sv
// Block-in / coefficient-out handshake bundle for y_zigzag_scanner.
// The master drives blocks in and accepts coefficients; the slave is the scanner.
interface y_zigzag_scanner_if #(
  parameter int unsigned DATA_W = 11
);
  logic                  in_valid;
  logic                  in_ready;
  logic [64*DATA_W-1:0]  in_block;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     out_data;
  logic [5:0]            out_index;
  logic                  out_last;

  modport master (
    output in_valid, in_block, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last
  );

  modport slave (
    input  in_valid, in_block, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last
  );
endinterface

// File: rtl/y_zigzag_scanner.sv
// Ping-pong 8x8 block buffer that streams coefficients in JPEG zigzag order.
// Define ZIGZAG_EOB_EN to end each scan at the last nonzero zigzag coefficient.
module y_zigzag_scanner #(
  parameter int unsigned DATA_W = 11
) (
  input logic            clk,
  input logic            rst,
  y_zigzag_scanner_if.slave bus
);
  localparam int unsigned NCOEF = 64;
  localparam int unsigned IDX_W = 6;
  localparam logic [IDX_W-1:0] K_MAX = IDX_W'(NCOEF - 1);
  localparam int ZZ [NCOEF] = '{
    0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

  typedef enum logic {IDLE, SCAN} state_t;

  state_t             state, state_n;
  logic [DATA_W-1:0]  bank [2][NCOEF];
  logic [1:0]         full, full_n;
  logic               wr_ptr, rd_ptr, rd_ptr_n;
  logic [IDX_W-1:0]   k, k_n;
  logic               load, xfer, last_xfer;
  logic [IDX_W-1:0]   last_n;
  logic [DATA_W-1:0]  data_n;

  function automatic logic [DATA_W-1:0] coef(input logic [NCOEF*DATA_W-1:0] blk,
                                             input logic [IDX_W-1:0] pos);
    return blk[int'(pos)*DATA_W +: DATA_W];
  endfunction

`ifdef ZIGZAG_EOB_EN
  logic [IDX_W-1:0] last_idx [2];
  logic [IDX_W-1:0] in_last;

  // Highest zigzag position holding a nonzero coefficient in the incoming block
  always_comb begin
    in_last = '0;
    for (int i = 0; i < int'(NCOEF); i++)
      if (coef(bus.in_block, IDX_W'(ZZ[i])) != '0) in_last = IDX_W'(i);
  end
`endif

  assign bus.in_ready = !full[wr_ptr];

  // Post-edge view of the buffers so outputs can be registered without a bubble
  always_comb begin
    load      = bus.in_valid && bus.in_ready;
    xfer      = (state == SCAN) && bus.out_ready;
    last_xfer = xfer && bus.out_last;
    full_n    = full;
    if (load)      full_n[wr_ptr] = 1'b1;
    if (last_xfer) full_n[rd_ptr] = 1'b0;
    rd_ptr_n  = last_xfer ? ~rd_ptr : rd_ptr;
    k_n       = last_xfer ? '0 : (xfer ? k + IDX_W'(1) : k);
    state_n   = full_n[rd_ptr_n] ? SCAN : IDLE;
    // A bank being loaded on this edge is read straight from the input bus
    if (load && (wr_ptr == rd_ptr_n)) begin
      data_n = coef(bus.in_block, IDX_W'(ZZ[k_n]));
`ifdef ZIGZAG_EOB_EN
      last_n = in_last;
`else
      last_n = K_MAX;
`endif
    end else begin
      data_n = bank[rd_ptr_n][IDX_W'(ZZ[k_n])];
`ifdef ZIGZAG_EOB_EN
      last_n = last_idx[rd_ptr_n];
`else
      last_n = K_MAX;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (load)
      for (int i = 0; i < int'(NCOEF); i++)
        bank[wr_ptr][i] <= coef(bus.in_block, IDX_W'(i));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      full          <= '0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      k             <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_index <= '0;
      bus.out_last  <= 1'b0;
`ifdef ZIGZAG_EOB_EN
      last_idx[0]   <= '0;
      last_idx[1]   <= '0;
`endif
    end else begin
      state  <= state_n;
      full   <= full_n;
      rd_ptr <= rd_ptr_n;
      k      <= k_n;
      if (load) wr_ptr <= ~wr_ptr;
`ifdef ZIGZAG_EOB_EN
      if (load) last_idx[wr_ptr] <= in_last;
`endif
      bus.out_valid <= (state_n == SCAN);
      bus.out_data  <= (state_n == SCAN) ? data_n : '0;
      bus.out_index <= (state_n == SCAN) ? k_n : '0;
      bus.out_last  <= (state_n == SCAN) && (k_n == last_n);
    end
  end
endmodule

// File: tb/tb_y_zigzag_scanner.sv
// Randomized bench for y_zigzag_scanner against a queue-of-beats reference model.
// The zigzag order is rebuilt by walking anti-diagonals, independent of the RTL table.
module tb_y_zigzag_scanner;
  localparam int DATA_W = 11;
  localparam int BW     = 64 * DATA_W;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [5:0]        idx;
    logic              last;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst;
  beat_t exp_q [$];
  int    nblk;
  int    total;
  int    bad;
  int    zz_ord [64];

  y_zigzag_scanner_if #(.DATA_W(DATA_W)) bus ();
  y_zigzag_scanner #(.DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic void build_zigzag();
    int n = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) for (int r = hi; r >= lo; r--) begin zz_ord[n] = r * 8 + (s - r); n++; end
      else            for (int r = lo; r <= hi; r++) begin zz_ord[n] = r * 8 + (s - r); n++; end
    end
  endfunction

  function automatic logic [DATA_W-1:0] cf(input logic [BW-1:0] blk, input int pos);
    return blk[pos*DATA_W +: DATA_W];
  endfunction

  function automatic void push_block(input logic [BW-1:0] blk);
    int    last = 63;
    beat_t b;
`ifdef ZIGZAG_EOB_EN
    last = 0;
    for (int k = 0; k < 64; k++) if (cf(blk, zz_ord[k]) != '0) last = k;
`endif
    for (int k = 0; k <= last; k++) begin
      b.d = cf(blk, zz_ord[k]); b.idx = 6'(k); b.last = (k == last);
      exp_q.push_back(b);
    end
  endfunction

  function automatic logic [BW-1:0] rand_block(input int pct_nonzero);
    logic [BW-1:0] blk;
    for (int i = 0; i < 64; i++)
      blk[i*DATA_W +: DATA_W] = ($urandom_range(0, 99) < pct_nonzero) ? DATA_W'($urandom) : '0;
    return blk;
  endfunction

  // Drive one cycle of inputs and advance the model by the handshakes that will occur
  task automatic step(input bit iv, input logic [BW-1:0] blk, input bit ordy, output bit acc);
    bus.in_valid  = iv;
    bus.in_block  = blk;
    bus.out_ready = ordy;
    acc = iv && (bus.in_ready === 1'b1);
    if (bus.out_valid === 1'b1 && ordy && exp_q.size() > 0) begin
      if (exp_q[0].last) nblk--;
      void'(exp_q.pop_front());
    end
    if (acc) begin push_block(blk); nblk++; end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.in_block = '0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.out_data !== '0) begin bad++; $display("FAIL reset_data: got %0d want 0", bus.out_data); end
    total++; if (bus.out_index !== 6'd0) begin bad++; $display("FAIL reset_index: got %0d want 0", bus.out_index); end
    total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL reset_last: got %b want 0", bus.out_last); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.in_ready); end
    rst = 1'b1;
  endtask

  task automatic test_ramp();
    logic [BW-1:0] blk;
    bit acc; bit sent = 0; int cyc = 0; int lasts = 0;
    for (int i = 0; i < 64; i++) blk[i*DATA_W +: DATA_W] = DATA_W'(i);
    do begin
      @(negedge clk);
      total++; if (bus.out_valid !== (exp_q.size() > 0)) begin bad++; $display("FAIL ramp_valid: got %b want %b", bus.out_valid, exp_q.size() > 0); end
      if (bus.out_valid === 1'b1 && exp_q.size() > 0) begin
        total++;
        if (bus.out_data !== exp_q[0].d || bus.out_index !== exp_q[0].idx || bus.out_last !== exp_q[0].last) begin
          bad++; $display("FAIL ramp_beat: got d=%0d k=%0d last=%b want d=%0d k=%0d last=%b", bus.out_data, bus.out_index, bus.out_last, exp_q[0].d, exp_q[0].idx, exp_q[0].last);
        end
        if (bus.out_last === 1'b1) lasts++;
      end
      step(!sent, blk, 1'b1, acc);
      if (acc) sent = 1;
      cyc++;
    end while ((!sent || exp_q.size() > 0) && cyc < 300);
    total++; if (exp_q.size() != 0 || !sent) begin bad++; $display("FAIL ramp_timeout: got %0d pending want 0", exp_q.size()); end
    total++; if (lasts != 1) begin bad++; $display("FAIL ramp_last_count: got %0d want 1", lasts); end
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] blks [2];
    bit acc; int sent = 0; int cyc = 0; int streak = 0; bit gap = 0;
    for (int i = 0; i < 64; i++) begin
      blks[0][i*DATA_W +: DATA_W] = DATA_W'(5);
      blks[1][i*DATA_W +: DATA_W] = DATA_W'(-3);
    end
    do begin
      @(negedge clk);
      total++; if (bus.out_valid !== (exp_q.size() > 0)) begin bad++; $display("FAIL b2b_valid: got %b want %b", bus.out_valid, exp_q.size() > 0); end
      if (bus.out_valid === 1'b1 && exp_q.size() > 0) begin
        total++;
        if (bus.out_data !== exp_q[0].d || bus.out_index !== exp_q[0].idx || bus.out_last !== exp_q[0].last) begin
          bad++; $display("FAIL b2b_beat: got d=%0d k=%0d last=%b want d=%0d k=%0d last=%b", bus.out_data, bus.out_index, bus.out_last, exp_q[0].d, exp_q[0].idx, exp_q[0].last);
        end
      end
      if (bus.out_valid === 1'b1) begin if (!gap) streak++; end
      else if (streak > 0) gap = 1;
      step(sent < 2, (sent < 2) ? blks[sent] : '0, 1'b1, acc);
      if (acc) sent++;
      cyc++;
    end while ((sent < 2 || exp_q.size() > 0) && cyc < 400);
    total++; if (exp_q.size() != 0 || sent < 2) begin bad++; $display("FAIL b2b_timeout: got %0d pending want 0", exp_q.size()); end
    total++; if (streak != 128) begin bad++; $display("FAIL b2b_streak: got %0d want 128", streak); end
  endtask

  task automatic test_backpressure();
    logic [BW-1:0] blk = rand_block(60);
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit acc; bit sent = 0; int cyc = 0; int want = 0; int got = 0; bit ordy;
    do begin
      @(negedge clk);
      ordy = pat[cyc % 4];
      total++; if (bus.out_valid !== (exp_q.size() > 0)) begin bad++; $display("FAIL bp_valid: got %b want %b", bus.out_valid, exp_q.size() > 0); end
      if (bus.out_valid === 1'b1 && exp_q.size() > 0) begin
        total++;
        if (bus.out_data !== exp_q[0].d || bus.out_index !== exp_q[0].idx || bus.out_last !== exp_q[0].last) begin
          bad++; $display("FAIL bp_beat: got d=%0d k=%0d last=%b want d=%0d k=%0d last=%b", bus.out_data, bus.out_index, bus.out_last, exp_q[0].d, exp_q[0].idx, exp_q[0].last);
        end
        if (ordy) got++;
      end
      step(!sent, blk, ordy, acc);
      if (acc) begin sent = 1; want = exp_q.size(); end
      cyc++;
    end while ((!sent || exp_q.size() > 0) && cyc < 600);
    total++; if (exp_q.size() != 0 || !sent) begin bad++; $display("FAIL bp_timeout: got %0d pending want 0", exp_q.size()); end
    total++; if (got != want) begin bad++; $display("FAIL bp_beat_count: got %0d want %0d", got, want); end
  endtask

  task automatic test_full();
    logic [BW-1:0] blks [3];
    bit acc; int sent = 0; int cyc = 0; int third_cyc = -1;
    for (int b = 0; b < 3; b++) begin
      blks[b] = rand_block(90);
      blks[b][63*DATA_W +: DATA_W] = DATA_W'(1);
    end
    do begin
      @(negedge clk);
      total++; if (bus.out_valid !== (exp_q.size() > 0)) begin bad++; $display("FAIL full_valid: got %b want %b", bus.out_valid, exp_q.size() > 0); end
      total++; if (bus.in_ready !== (nblk < 2)) begin bad++; $display("FAIL full_ready: got %b want %b", bus.in_ready, nblk < 2); end
      if (bus.out_valid === 1'b1 && exp_q.size() > 0) begin
        total++;
        if (bus.out_data !== exp_q[0].d || bus.out_index !== exp_q[0].idx || bus.out_last !== exp_q[0].last) begin
          bad++; $display("FAIL full_beat: got d=%0d k=%0d last=%b want d=%0d k=%0d last=%b", bus.out_data, bus.out_index, bus.out_last, exp_q[0].d, exp_q[0].idx, exp_q[0].last);
        end
      end
      step(sent < 3, (sent < 3) ? blks[sent] : '0, cyc >= 8, acc);
      if (acc) begin if (sent == 2) third_cyc = cyc; sent++; end
      cyc++;
    end while ((sent < 3 || exp_q.size() > 0) && cyc < 600);
    total++; if (exp_q.size() != 0 || sent < 3) begin bad++; $display("FAIL full_timeout: got %0d pending want 0", exp_q.size()); end
    total++; if (third_cyc != 72) begin bad++; $display("FAIL full_third_accept: got cycle %0d want 72", third_cyc); end
  endtask

  task automatic test_reset_mid();
    logic [BW-1:0] blk = rand_block(90);
    bit acc; bit sent = 0; bit hit = 0; int cyc = 0;
    blk[63*DATA_W +: DATA_W] = DATA_W'(2);
    do begin
      @(negedge clk);
      if (bus.out_valid === 1'b1 && exp_q.size() > 0 && exp_q[0].idx == 6'd20) hit = 1;
      else step(!sent, blk, 1'b1, acc);
      if (acc) sent = 1;
      cyc++;
    end while (!hit && cyc < 100);
    total++; if (!hit) begin bad++; $display("FAIL rstmid_reach: got k=%0d want 20", bus.out_index); end
    rst = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready: got %b want 1", bus.in_ready); end
    exp_q.delete(); nblk = 0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    blk = rand_block(50);
    sent = 0; cyc = 0;
    do begin
      @(negedge clk);
      total++; if (bus.out_valid !== (exp_q.size() > 0)) begin bad++; $display("FAIL rstmid2_valid: got %b want %b", bus.out_valid, exp_q.size() > 0); end
      if (bus.out_valid === 1'b1 && exp_q.size() > 0) begin
        total++;
        if (bus.out_data !== exp_q[0].d || bus.out_index !== exp_q[0].idx || bus.out_last !== exp_q[0].last) begin
          bad++; $display("FAIL rstmid2_beat: got d=%0d k=%0d last=%b want d=%0d k=%0d last=%b", bus.out_data, bus.out_index, bus.out_last, exp_q[0].d, exp_q[0].idx, exp_q[0].last);
        end
      end
      step(!sent, blk, 1'b1, acc);
      if (acc) sent = 1;
      cyc++;
    end while ((!sent || exp_q.size() > 0) && cyc < 300);
    total++; if (exp_q.size() != 0 || !sent) begin bad++; $display("FAIL rstmid2_timeout: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_eob();
    logic [BW-1:0] blks [2];
    bit acc; int sent = 0; int cyc = 0; int beats = 0; int want;
    blks[0] = '0; blks[1] = '0;
    blks[0][0*DATA_W +: DATA_W] = DATA_W'(7);
    blks[0][8*DATA_W +: DATA_W] = DATA_W'(-1);
`ifdef ZIGZAG_EOB_EN
    want = 4;
`else
    want = 128;
`endif
    do begin
      @(negedge clk);
      total++; if (bus.out_valid !== (exp_q.size() > 0)) begin bad++; $display("FAIL eob_valid: got %b want %b", bus.out_valid, exp_q.size() > 0); end
      if (bus.out_valid === 1'b1 && exp_q.size() > 0) begin
        total++;
        if (bus.out_data !== exp_q[0].d || bus.out_index !== exp_q[0].idx || bus.out_last !== exp_q[0].last) begin
          bad++; $display("FAIL eob_beat: got d=%0d k=%0d last=%b want d=%0d k=%0d last=%b", bus.out_data, bus.out_index, bus.out_last, exp_q[0].d, exp_q[0].idx, exp_q[0].last);
        end
        beats++;
      end
      step(sent < 2, (sent < 2) ? blks[sent] : '0, 1'b1, acc);
      if (acc) sent++;
      cyc++;
    end while ((sent < 2 || exp_q.size() > 0) && cyc < 400);
    total++; if (exp_q.size() != 0 || sent < 2) begin bad++; $display("FAIL eob_timeout: got %0d pending want 0", exp_q.size()); end
    total++; if (beats != want) begin bad++; $display("FAIL eob_beat_count: got %0d want %0d", beats, want); end
  endtask

  task automatic test_random();
    logic [BW-1:0] blks [10];
    bit acc; int sent = 0; int cyc = 0;
    for (int b = 0; b < 10; b++) blks[b] = (b % 4 == 3) ? '0 : rand_block($urandom_range(2, 60));
    do begin
      @(negedge clk);
      total++; if (bus.out_valid !== (exp_q.size() > 0)) begin bad++; $display("FAIL rand_valid: got %b want %b", bus.out_valid, exp_q.size() > 0); end
      total++; if (bus.in_ready !== (nblk < 2)) begin bad++; $display("FAIL rand_ready: got %b want %b", bus.in_ready, nblk < 2); end
      if (bus.out_valid === 1'b1 && exp_q.size() > 0) begin
        total++;
        if (bus.out_data !== exp_q[0].d || bus.out_index !== exp_q[0].idx || bus.out_last !== exp_q[0].last) begin
          bad++; $display("FAIL rand_beat: got d=%0d k=%0d last=%b want d=%0d k=%0d last=%b", bus.out_data, bus.out_index, bus.out_last, exp_q[0].d, exp_q[0].idx, exp_q[0].last);
        end
      end
      step(sent < 10 && $urandom_range(0, 1) == 1, (sent < 10) ? blks[sent] : '0, $urandom_range(0, 3) != 0, acc);
      if (acc) sent++;
      cyc++;
    end while ((sent < 10 || exp_q.size() > 0) && cyc < 4000);
    total++; if (exp_q.size() != 0 || sent < 10) begin bad++; $display("FAIL rand_timeout: got %0d pending want 0", exp_q.size()); end
  endtask

  initial begin
    total = 0; bad = 0; nblk = 0;
    build_zigzag();
    test_reset();
    test_ramp();
    test_back_to_back();
    test_backpressure();
    test_full();
    test_reset_mid();
    test_eob();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
